// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the writeback path
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/riscv_wb_fifo.sv
// rtl/riscv_wb_fifo.sv - small load result buffer with registered occupancy
module riscv_wb_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  riscv_pkg::wb_req_t         push_data,
   input  logic                       pop,
   output riscv_pkg::wb_req_t         pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   import riscv_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_req_t         mem_q [DEPTH];
   wb_req_t         mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   // next-state for storage, pointers (wrap naturally, depth is a power of 2) and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // state registers; reset empties the buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);

endmodule

// File: rtl/riscv_wb_ctrl.sv
// rtl/riscv_wb_ctrl.sv - writeback arbitration, register file write port, scoreboard and forwarding
module riscv_wb_ctrl #(
   parameter int XLEN       = riscv_pkg::XLEN,
   parameter int LBUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_iss_valid,
   input  logic [4:0]      i_iss_rd,
   output logic [31:0]     o_busy,
   input  logic            i_alu_valid,
   input  logic [4:0]      i_alu_rd,
   input  logic [XLEN-1:0] i_alu_data,
   input  logic            i_lsu_valid,
   input  logic [4:0]      i_lsu_rd,
   input  logic [XLEN-1:0] i_lsu_data,
   output logic            o_lsu_ready,
   output logic            o_we,
   output logic [4:0]      o_waddr,
   output logic [XLEN-1:0] o_wdata,
   input  logic [4:0]      i_raddr1,
   input  logic [4:0]      i_raddr2,
   output logic            o_fwd1_hit,
   output logic            o_fwd2_hit
);
   import riscv_pkg::*;

   localparam int CW = $clog2(LBUF_DEPTH) + 1;

   wb_req_t         lbuf_push_data;
   wb_req_t         lbuf_head;
   logic            lbuf_push;
   logic            lbuf_pop;
   logic            lbuf_full;
   logic            lbuf_empty;
   logic [CW-1:0]   lbuf_count;

   logic            sel_valid;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;

   logic            we_q, we_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [31:0]     busy_q, busy_d;

   // ready comes only from the registered occupancy, so the pop never reaches it combinationally
   assign o_lsu_ready       = (lbuf_count < CW'(LBUF_DEPTH));
   assign lbuf_push         = i_lsu_valid & o_lsu_ready;
   assign lbuf_push_data.rd   = i_lsu_rd;
   assign lbuf_push_data.data = i_lsu_data;

   riscv_wb_fifo #(
      .DEPTH (LBUF_DEPTH)
   ) u_lbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lbuf_push),
      .push_data (lbuf_push_data),
      .pop       (lbuf_pop),
      .pop_data  (lbuf_head),
      .full      (lbuf_full),
      .empty     (lbuf_empty),
      .count     (lbuf_count)
   );

   // arbitration: ALU has strict priority, otherwise drain the load buffer head
   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = REG_ZERO;
      sel_data  = '0;
      lbuf_pop  = 1'b0;
      if (i_alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = i_alu_rd;
         sel_data  = i_alu_data;
      end else if (!lbuf_empty) begin
         sel_valid = 1'b1;
         sel_rd    = lbuf_head.rd;
         sel_data  = lbuf_head.data;
         lbuf_pop  = 1'b1;
      end
   end

   // write stage and scoreboard next-state; writes to x0 are consumed but never enabled
   always_comb begin
      we_d    = sel_valid & (sel_rd != REG_ZERO);
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (we_d) begin
         waddr_d = sel_rd;
         wdata_d = sel_data;
      end
      busy_d = busy_q;
      if (we_d) busy_d[sel_rd] = 1'b0;
      // a same-cycle issue means a newer writer is pending, so the set overrides the clear
      if (i_iss_valid && (i_iss_rd != REG_ZERO)) busy_d[i_iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // registered write port and scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= REG_ZERO;
         wdata_q <= '0;
         busy_q  <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   assign o_we    = we_q;
   assign o_waddr = waddr_q;
   assign o_wdata = wdata_q;
   assign o_busy  = busy_q;

   assign o_fwd1_hit = we_q & (waddr_q == i_raddr1) & (i_raddr1 != REG_ZERO);
   assign o_fwd2_hit = we_q & (waddr_q == i_raddr2) & (i_raddr2 != REG_ZERO);

   // issue stage must not target a register whose writer is still outstanding (unless it retires now)
   a_no_waw_issue : assert property (@(posedge clk) disable iff (!rst_n)
      (i_iss_valid && (i_iss_rd != REG_ZERO)) |->
         (!busy_q[i_iss_rd] || (we_d && (sel_rd == i_iss_rd))));

   // ready already gates the push, so the buffer can never overflow
   a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
      !(lbuf_push && lbuf_full));

endmodule

// File: tb/tb_riscv_wb_ctrl.sv
// tb/tb_riscv_wb_ctrl.sv - directed self-checking bench for riscv_wb_ctrl
module tb_riscv_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_iss_valid;
   logic [4:0]  i_iss_rd;
   logic [31:0] o_busy;
   logic        i_alu_valid;
   logic [4:0]  i_alu_rd;
   logic [31:0] i_alu_data;
   logic        i_lsu_valid;
   logic [4:0]  i_lsu_rd;
   logic [31:0] i_lsu_data;
   logic        o_lsu_ready;
   logic        o_we;
   logic [4:0]  o_waddr;
   logic [31:0] o_wdata;
   logic [4:0]  i_raddr1;
   logic [4:0]  i_raddr2;
   logic        o_fwd1_hit;
   logic        o_fwd2_hit;

   int total = 0;
   int bad   = 0;

   riscv_wb_ctrl #(.XLEN(32), .LBUF_DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_iss_valid (i_iss_valid),
      .i_iss_rd    (i_iss_rd),
      .o_busy      (o_busy),
      .i_alu_valid (i_alu_valid),
      .i_alu_rd    (i_alu_rd),
      .i_alu_data  (i_alu_data),
      .i_lsu_valid (i_lsu_valid),
      .i_lsu_rd    (i_lsu_rd),
      .i_lsu_data  (i_lsu_data),
      .o_lsu_ready (o_lsu_ready),
      .o_we        (o_we),
      .o_waddr     (o_waddr),
      .o_wdata     (o_wdata),
      .i_raddr1    (i_raddr1),
      .i_raddr2    (i_raddr2),
      .o_fwd1_hit  (o_fwd1_hit),
      .o_fwd2_hit  (o_fwd2_hit)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_iss_valid = 1'b0; i_iss_rd = 5'd0;
      i_alu_valid = 1'b0; i_alu_rd = 5'd0; i_alu_data = 32'h0;
      i_lsu_valid = 1'b0; i_lsu_rd = 5'd0; i_lsu_data = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      i_raddr1 = 5'd0; i_raddr2 = 5'd0;
      #12;
      total++; if (o_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", o_we); end
      total++; if (o_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", o_waddr); end
      total++; if (o_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", o_wdata); end
      total++; if (o_busy !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", o_busy); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      total++; if (o_lsu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_lsu_ready); end
   endtask

   task automatic test_alu();
      i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
      cyc();
      idle();
      total++; if (o_we !== 1'b1) begin bad++; $display("FAIL alu_we: got %b want 1", o_we); end
      total++; if (o_waddr !== 5'd5) begin bad++; $display("FAIL alu_waddr: got %0d want 5", o_waddr); end
      total++; if (o_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_wdata: got %h want deadbeef", o_wdata); end
      cyc();
      total++; if (o_we !== 1'b0) begin bad++; $display("FAIL alu_we_drop: got %b want 0", o_we); end
      total++; if (o_waddr !== 5'd5 || o_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_hold: got %0d/%h want 5/deadbeef", o_waddr, o_wdata); end
   endtask

   task automatic test_backpressure();
      i_alu_valid = 1'b1; i_alu_rd = 5'd11; i_alu_data = 32'h11;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd3;  i_lsu_data = 32'h33;
      cyc();
      total++; if (o_we !== 1'b1 || o_waddr !== 5'd11) begin bad++; $display("FAIL bp_alu0: got %b/%0d want 1/11", o_we, o_waddr); end
      total++; if (o_lsu_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1: got %b want 1", o_lsu_ready); end
      i_alu_rd = 5'd12; i_alu_data = 32'h12;
      i_lsu_rd = 5'd4;  i_lsu_data = 32'h44;
      cyc();
      total++; if (o_lsu_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", o_lsu_ready); end
      i_alu_rd = 5'd13; i_alu_data = 32'h13;
      i_lsu_valid = 1'b0;
      cyc();
      total++; if (o_waddr !== 5'd13 || o_lsu_ready !== 1'b0) begin bad++; $display("FAIL bp_alu2: got %0d/%b want 13/0", o_waddr, o_lsu_ready); end
      idle();
      cyc();
      total++; if (o_we !== 1'b1 || o_waddr !== 5'd3 || o_wdata !== 32'h33) begin bad++; $display("FAIL bp_load3: got %b/%0d/%h want 1/3/33", o_we, o_waddr, o_wdata); end
      total++; if (o_lsu_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_free: got %b want 1", o_lsu_ready); end
      cyc();
      total++; if (o_we !== 1'b1 || o_waddr !== 5'd4 || o_wdata !== 32'h44) begin bad++; $display("FAIL bp_load4: got %b/%0d/%h want 1/4/44", o_we, o_waddr, o_wdata); end
      cyc();
      total++; if (o_we !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", o_we); end
   endtask

   task automatic test_same_cycle();
      i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h77;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd8; i_lsu_data = 32'h88;
      cyc();
      idle();
      total++; if (o_we !== 1'b1 || o_waddr !== 5'd7 || o_wdata !== 32'h77) begin bad++; $display("FAIL same_x7: got %b/%0d/%h want 1/7/77", o_we, o_waddr, o_wdata); end
      cyc();
      total++; if (o_we !== 1'b1 || o_waddr !== 5'd8 || o_wdata !== 32'h88) begin bad++; $display("FAIL same_x8: got %b/%0d/%h want 1/8/88", o_we, o_waddr, o_wdata); end
      cyc();
      total++; if (o_we !== 1'b0) begin bad++; $display("FAIL same_drain: got %b want 0", o_we); end
   endtask

   task automatic test_scoreboard();
      i_iss_valid = 1'b1; i_iss_rd = 5'd9;
      cyc();
      idle();
      total++; if (o_busy !== 32'h0000_0200) begin bad++; $display("FAIL sb_set: got %h want 00000200", o_busy); end
      i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h99;
      cyc();
      idle();
      total++; if (o_we !== 1'b1 || o_busy !== 32'h0) begin bad++; $display("FAIL sb_clear: got %b/%h want 1/0", o_we, o_busy); end
      i_iss_valid = 1'b1; i_iss_rd = 5'd9;
      cyc();
      i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h9A;
      cyc();
      idle();
      total++; if (o_we !== 1'b1 || o_waddr !== 5'd9 || o_busy !== 32'h0000_0200) begin bad++; $display("FAIL sb_set_wins: got %b/%0d/%h want 1/9/00000200", o_we, o_waddr, o_busy); end
      i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h9B;
      cyc();
      idle();
      total++; if (o_busy !== 32'h0) begin bad++; $display("FAIL sb_final_clear: got %h want 0", o_busy); end
   endtask

   task automatic test_rd0();
      i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h1234;
      i_iss_valid = 1'b1; i_iss_rd = 5'd0;
      cyc();
      idle();
      total++; if (o_we !== 1'b0 || o_busy !== 32'h0) begin bad++; $display("FAIL rd0_alu: got %b/%h want 0/0", o_we, o_busy); end
      total++; if (o_waddr !== 5'd9 || o_wdata !== 32'h9B) begin bad++; $display("FAIL rd0_hold: got %0d/%h want 9/9b", o_waddr, o_wdata); end
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_data = 32'h5555;
      cyc();
      i_lsu_rd = 5'd14; i_lsu_data = 32'hE0;
      cyc();
      idle();
      total++; if (o_we !== 1'b0) begin bad++; $display("FAIL rd0_load_drop: got %b want 0", o_we); end
      cyc();
      total++; if (o_we !== 1'b1 || o_waddr !== 5'd14 || o_wdata !== 32'hE0) begin bad++; $display("FAIL rd0_next_load: got %b/%0d/%h want 1/14/e0", o_we, o_waddr, o_wdata); end
      cyc();
   endtask

   task automatic test_forward();
      i_alu_valid = 1'b1; i_alu_rd = 5'd10; i_alu_data = 32'hA0;
      cyc();
      idle();
      i_raddr1 = 5'd10; i_raddr2 = 5'd10;
      #1;
      total++; if (o_fwd1_hit !== 1'b1 || o_fwd2_hit !== 1'b1) begin bad++; $display("FAIL fwd_both: got %b%b want 11", o_fwd1_hit, o_fwd2_hit); end
      i_raddr1 = 5'd5;
      #1;
      total++; if (o_fwd1_hit !== 1'b0 || o_fwd2_hit !== 1'b1) begin bad++; $display("FAIL fwd_one: got %b%b want 01", o_fwd1_hit, o_fwd2_hit); end
      cyc();
      total++; if (o_fwd2_hit !== 1'b0) begin bad++; $display("FAIL fwd_no_we: got %b want 0", o_fwd2_hit); end
      i_raddr1 = 5'd0; i_raddr2 = 5'd0;
   endtask

   task automatic test_reset_mid();
      i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'h1;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd15; i_lsu_data = 32'hF;
      i_iss_valid = 1'b1; i_iss_rd = 5'd17;
      cyc();
      i_alu_rd = 5'd2; i_alu_data = 32'h2;
      i_lsu_rd = 5'd16; i_lsu_data = 32'h10;
      i_iss_valid = 1'b0;
      cyc();
      total++; if (o_lsu_ready !== 1'b0 || o_busy !== 32'h0002_0000) begin bad++; $display("FAIL mid_pre: got %b/%h want 0/00020000", o_lsu_ready, o_busy); end
      i_alu_rd = 5'd3; i_alu_data = 32'h3;
      i_lsu_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (o_we !== 1'b0 || o_busy !== 32'h0 || o_waddr !== 5'd0) begin bad++; $display("FAIL mid_async: got %b/%h/%0d want 0/0/0", o_we, o_busy, o_waddr); end
      idle();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++; if (o_we !== 1'b0 || o_lsu_ready !== 1'b1) begin bad++; $display("FAIL mid_after_%0d: got we=%b ready=%b want 0/1", i, o_we, o_lsu_ready); end
      end
      i_raddr1 = 5'd0;
      #1;
      total++; if (o_fwd1_hit !== 1'b0) begin bad++; $display("FAIL fwd_zero: got %b want 0", o_fwd1_hit); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_backpressure();
      test_same_cycle();
      test_scoreboard();
      test_rd0();
      test_forward();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
